// File: rtl/npn4_pkg.sv
// npn4_pkg: shared types, permutation table and helpers for the 4-input NPN canonicalizer
package npn4_pkg;
  localparam int TT_W = 16;
  localparam int N_PERM = 24;
  localparam int N_NEG = 16;
  localparam int SCAN_CYCLES = N_PERM * N_NEG;
  typedef logic [TT_W-1:0] tt_t;
  typedef logic [3:0][1:0] perm_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  // Nibbles read left to right as P[0],P[1],P[2],P[3] so the table below matches lexicographic order.
  function automatic perm_t perm_of_hex(logic [15:0] h);
    perm_t r;
    for (int i = 0; i < 4; i++) r[i] = h[13-4*i -: 2];
    return r;
  endfunction
  localparam perm_t PERM_TABLE [N_PERM] = '{
    perm_of_hex(16'h0123), perm_of_hex(16'h0132), perm_of_hex(16'h0213), perm_of_hex(16'h0231),
    perm_of_hex(16'h0312), perm_of_hex(16'h0321), perm_of_hex(16'h1023), perm_of_hex(16'h1032),
    perm_of_hex(16'h1203), perm_of_hex(16'h1230), perm_of_hex(16'h1302), perm_of_hex(16'h1320),
    perm_of_hex(16'h2013), perm_of_hex(16'h2031), perm_of_hex(16'h2103), perm_of_hex(16'h2130),
    perm_of_hex(16'h2301), perm_of_hex(16'h2310), perm_of_hex(16'h3012), perm_of_hex(16'h3021),
    perm_of_hex(16'h3102), perm_of_hex(16'h3120), perm_of_hex(16'h3201), perm_of_hex(16'h3210)
  };
  // Source minterm j feeding output minterm m: j[P[i]] = m[i] ^ N[i].
  function automatic logic [3:0] src_minterm(perm_t p, logic [3:0] n, logic [3:0] m);
    logic [3:0] j;
    j = '0;
    for (int i = 0; i < 4; i++) j[p[i]] = m[i] ^ n[i];
    return j;
  endfunction
endpackage

// File: rtl/npn4_apply.sv
// npn4_apply: combinational input permutation/negation of a 4-input truth table
module npn4_apply
  import npn4_pkg::*;
(
  input  tt_t        tt,
  input  logic [4:0] perm_idx,
  input  logic [3:0] neg,
  output tt_t        g
);
  perm_t p;
  assign p = PERM_TABLE[perm_idx];
  for (genvar m = 0; m < TT_W; m++) begin : g_mux
    assign g[m] = tt[src_minterm(p, neg, 4'(m))];
  end
endmodule

// File: rtl/npn4_canonicalizer.sv
// npn4_canonicalizer: exhaustive one-transform-per-cycle NPN canonical form search
module npn4_canonicalizer
  import npn4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_tt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_canon,
  output logic [4:0]  out_perm,
  output logic [3:0]  out_neg,
  output logic        out_oneg
);
  state_t state_q, state_d;
  tt_t tt_q, tt_d, best_q, best_d, canon_q, canon_d, t, cand;
  logic [4:0] perm_cnt_q, perm_cnt_d, best_perm_q, best_perm_d, perm_q, perm_d;
  logic [3:0] neg_cnt_q, neg_cnt_d, best_neg_q, best_neg_d, neg_q, neg_d;
  logic best_oneg_q, best_oneg_d, oneg_q, oneg_d, cand_oneg, take, last;
  npn4_apply u_apply (.tt(tt_q), .perm_idx(perm_cnt_q), .neg(neg_cnt_q), .g(t));
  assign cand_oneg = ~t < t;
  assign cand = cand_oneg ? ~t : t;
  assign take = (perm_cnt_q == '0 && neg_cnt_q == '0) || cand < best_q;
  assign last = perm_cnt_q == 5'(N_PERM - 1) && neg_cnt_q == 4'(N_NEG - 1);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_canon = canon_q;
  assign out_perm = perm_q;
  assign out_neg = neg_q;
  assign out_oneg = oneg_q;
  // Next state: capture on handshake, track running minimum while scanning, publish on the last transform.
  always_comb begin
    state_d = state_q;
    tt_d = tt_q;
    perm_cnt_d = perm_cnt_q;
    neg_cnt_d = neg_cnt_q;
    best_d = best_q;
    best_perm_d = best_perm_q;
    best_neg_d = best_neg_q;
    best_oneg_d = best_oneg_q;
    canon_d = canon_q;
    perm_d = perm_q;
    neg_d = neg_q;
    oneg_d = oneg_q;
    if (state_q == IDLE && in_valid) begin
      state_d = SCAN;
      tt_d = in_tt;
      perm_cnt_d = '0;
      neg_cnt_d = '0;
    end else if (state_q == SCAN) begin
      best_d = take ? cand : best_q;
      best_perm_d = take ? perm_cnt_q : best_perm_q;
      best_neg_d = take ? neg_cnt_q : best_neg_q;
      best_oneg_d = take ? cand_oneg : best_oneg_q;
      neg_cnt_d = neg_cnt_q + 4'd1;
      perm_cnt_d = perm_cnt_q + 5'(neg_cnt_q == 4'(N_NEG - 1));
      state_d = last ? DONE : SCAN;
      canon_d = last ? best_d : canon_q;
      perm_d = last ? best_perm_d : perm_q;
      neg_d = last ? best_neg_d : neg_q;
      oneg_d = last ? best_oneg_d : oneg_q;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  // State registers with synchronous reset discarding any partial search.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tt_q <= '0;
      perm_cnt_q <= '0;
      neg_cnt_q <= '0;
      best_q <= '0;
      best_perm_q <= '0;
      best_neg_q <= '0;
      best_oneg_q <= 1'b0;
      canon_q <= '0;
      perm_q <= '0;
      neg_q <= '0;
      oneg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tt_q <= tt_d;
      perm_cnt_q <= perm_cnt_d;
      neg_cnt_q <= neg_cnt_d;
      best_q <= best_d;
      best_perm_q <= best_perm_d;
      best_neg_q <= best_neg_d;
      best_oneg_q <= best_oneg_d;
      canon_q <= canon_d;
      perm_q <= perm_d;
      neg_q <= neg_d;
      oneg_q <= oneg_d;
    end
  end
endmodule

// File: tb/tb_npn4_canonicalizer.sv
// tb_npn4_canonicalizer: directed and randomized checks against an exhaustive NPN reference model
module tb_npn4_canonicalizer;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_oneg;
  logic [15:0] in_tt, out_canon;
  logic [4:0] out_perm;
  logic [3:0] out_neg;
  int tests = 0;
  int fails = 0;
  int perms [24][4];

  npn4_canonicalizer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tt(in_tt),
    .out_valid(out_valid), .out_ready(out_ready), .out_canon(out_canon),
    .out_perm(out_perm), .out_neg(out_neg), .out_oneg(out_oneg)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] xform(logic [15:0] f, int pi, int n, int o);
    logic [15:0] g;
    for (int m = 0; m < 16; m++) begin
      int j = 0;
      for (int i = 0; i < 4; i++)
        if ((((m >> i) ^ (n >> i)) & 1) != 0) j = j | (1 << perms[pi][i]);
      g[m] = f[j] ^ o[0];
    end
    return g;
  endfunction

  task automatic model(input logic [15:0] f, output logic [15:0] canon, output int mp, output int mn, output int mo);
    logic [15:0] t, c;
    bit found = 0;
    canon = 16'hFFFF;
    for (int p = 0; p < 24; p++)
      for (int n = 0; n < 16; n++)
        for (int o = 0; o < 2; o++)
          if (xform(f, p, n, o) < canon) canon = xform(f, p, n, o);
    mp = 0; mn = 0; mo = 0;
    for (int p = 0; p < 24; p++)
      for (int n = 0; n < 16; n++) begin
        t = xform(f, p, n, 0);
        c = (t <= ~t) ? t : ~t;
        if (!found && c == canon) begin
          found = 1; mp = p; mn = n; mo = (c != t) ? 1 : 0;
        end
      end
  endtask

  task automatic start(input logic [15:0] tt);
    @(negedge clk);
    in_valid = 1'b1;
    in_tt = tt;
    @(negedge clk);
    in_valid = 1'b0;
    in_tt = 16'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_canon !== 16'h0 || out_perm !== 5'd0 || out_neg !== 4'h0 || out_oneg !== 1'b0) begin
      fails++;
      $display("FAIL reset: rdy=%b vld=%b canon=%h perm=%0d neg=%h oneg=%b, expected 1 0 0000 0 0 0", in_ready, out_valid, out_canon, out_perm, out_neg, out_oneg);
    end
  endtask

  task automatic test_directed();
    logic [15:0] vt [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h6996};
    logic [15:0] vc [4] = '{16'h0000, 16'h0000, 16'h0001, 16'h6996};
    logic [3:0] vn [4] = '{4'h0, 4'h0, 4'hF, 4'h0};
    logic vo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    for (int k = 0; k < 4; k++) begin
      start(vt[k]);
      wait_done(lat);
      tests++;
      if (lat != 385 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL latency %h: got %0d valid=%b, expected 385", vt[k], lat, out_valid);
      end
      tests++;
      if (out_canon !== vc[k] || out_perm !== 5'd0 || out_neg !== vn[k] || out_oneg !== vo[k]) begin
        fails++;
        $display("FAIL directed %h: canon=%h perm=%0d neg=%h oneg=%b, expected %h 0 %h %b", vt[k], out_canon, out_perm, out_neg, out_oneg, vc[k], vn[k], vo[k]);
      end
      drain();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_canon !== vc[k]) begin
        fails++;
        $display("FAIL release %h: vld=%b rdy=%b canon=%h, expected 0 1 %h", vt[k], out_valid, in_ready, out_canon, vc[k]);
      end
    end
  endtask

  task automatic test_single_var();
    logic [15:0] mc;
    int mp, mn, mo, lat;
    model(16'hAAAA, mc, mp, mn, mo);
    start(16'hAAAA);
    wait_done(lat);
    tests++;
    if (out_valid !== 1'b1 || out_canon !== 16'h00FF) begin
      fails++;
      $display("FAIL x0 canon: got %h valid=%b, expected 00ff", out_canon, out_valid);
    end
    tests++;
    if (xform(16'hAAAA, int'(out_perm), int'(out_neg), int'(out_oneg)) !== out_canon || int'(out_perm) != mp || int'(out_neg) != mn || int'(out_oneg) != mo) begin
      fails++;
      $display("FAIL x0 transform: got p=%0d n=%0d o=%0d, expected p=%0d n=%0d o=%0d", out_perm, out_neg, out_oneg, mp, mn, mo);
    end
    drain();
  endtask

  task automatic test_busy_ignored();
    int lat;
    start(16'h8000);
    in_valid = 1'b1;
    in_tt = 16'hFFFF;
    out_ready = 1'b1;
    wait_done(lat);
    tests++;
    if (out_valid !== 1'b1 || out_canon !== 16'h0001 || out_neg !== 4'hF || lat != 385) begin
      fails++;
      $display("FAIL busy_ignored: canon=%h neg=%h lat=%0d, expected 0001 f 385", out_canon, out_neg, lat);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL busy_release: rdy=%b vld=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    start(16'h1234);
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_canon !== 16'h0 || out_perm !== 5'd0 || out_neg !== 4'h0 || out_oneg !== 1'b0) begin
      fails++;
      $display("FAIL mid_scan_reset: rdy=%b vld=%b canon=%h perm=%0d neg=%h oneg=%b, expected 1 0 0000 0 0 0", in_ready, out_valid, out_canon, out_perm, out_neg, out_oneg);
    end
    start(16'h8000);
    wait_done(lat);
    tests++;
    if (out_valid !== 1'b1 || lat != 385 || out_canon !== 16'h0001 || out_perm !== 5'd0 || out_neg !== 4'hF || out_oneg !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: canon=%h perm=%0d neg=%h oneg=%b lat=%0d, expected 0001 0 f 0 385", out_canon, out_perm, out_neg, out_oneg, lat);
    end
    drain();
  endtask

  task automatic test_random_sweep();
    logic [15:0] f, mc, s_canon;
    logic [4:0] s_perm;
    logic [3:0] s_neg;
    logic s_oneg;
    int mp, mn, mo, lat;
    for (int k = 0; k < 120; k++) begin
      f = (k % 3 == 0) ? 16'($urandom) & 16'($urandom) : 16'($urandom);
      model(f, mc, mp, mn, mo);
      start(f);
      wait_done(lat);
      tests++;
      if (out_valid !== 1'b1 || out_canon !== mc) begin
        fails++;
        $display("FAIL rand_canon %h: got %h valid=%b, expected %h", f, out_canon, out_valid, mc);
      end
      tests++;
      if (xform(f, int'(out_perm), int'(out_neg), int'(out_oneg)) !== out_canon) begin
        fails++;
        $display("FAIL rand_invariant %h: p=%0d n=%h o=%b gives %h, expected %h", f, out_perm, out_neg, out_oneg, xform(f, int'(out_perm), int'(out_neg), int'(out_oneg)), out_canon);
      end
      tests++;
      if (int'(out_perm) != mp || int'(out_neg) != mn || int'(out_oneg) != mo) begin
        fails++;
        $display("FAIL rand_first %h: got p=%0d n=%0d o=%0d, expected p=%0d n=%0d o=%0d", f, out_perm, out_neg, out_oneg, mp, mn, mo);
      end
      s_canon = out_canon; s_perm = out_perm; s_neg = out_neg; s_oneg = out_oneg;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_canon !== s_canon || out_perm !== s_perm || out_neg !== s_neg || out_oneg !== s_oneg) begin
          fails++;
          $display("FAIL rand_hold %h: vld=%b canon=%h p=%0d n=%h o=%b, expected 1 %h %0d %h %b", f, out_valid, out_canon, out_perm, out_neg, out_oneg, s_canon, s_perm, s_neg, s_oneg);
        end
      end
      drain();
    end
  endtask

  initial begin
    int idx = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          for (int d = 0; d < 4; d++)
            if (a != b && a != c && a != d && b != c && b != d && c != d) begin
              perms[idx] = '{a, b, c, d};
              idx++;
            end
    rst = 1'b1;
    in_valid = 1'b0;
    in_tt = 16'h0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_single_var();
    test_busy_ignored();
    test_reset_mid_scan();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
